// File: rtl/program_loader_if.sv
// Loader bus: received byte strobe in, instruction-memory write port out.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 13
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/count/data/checksum frames into little-endian
// instruction words and holds the CPU in reset until a frame verifies.
module program_loader #(
    parameter int unsigned ADDR_W         = 13,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
    input  logic             clk,
    input  logic             reset_low,
    program_loader_if.master bus,
    output logic             cpu_reset,
    output logic             busy,
    output logic             load_done,
    output logic             load_error
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StCntHi, StCntLo, StData, StCheck, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       widx_q, widx_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       n_words;
    logic              active;

    assign active = (state_q == StCntHi) || (state_q == StCntLo) ||
                    (state_q == StData)  || (state_q == StCheck);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        idx_d   = idx_q;
        word_d  = word_q;
        chk_d   = chk_q;
        tmo_d   = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        n_words = {cnt_q[15:8], bus.rx_data};

        if (active && !bus.rx_valid) begin
            tmo_d = tmo_q + TmoW'(1);
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) state_d = StError;
        end

        if (bus.rx_valid) begin
            case (state_q)
                StIdle, StDone, StError: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        state_d = StCntHi;
                        cnt_d   = '0;
                        chk_d   = '0;
                        widx_d  = '0;
                        idx_d   = '0;
                    end
                end
                StCntHi: begin
                    cnt_d[15:8] = bus.rx_data;
                    chk_d       = chk_q ^ bus.rx_data;
                    state_d     = StCntLo;
                end
                StCntLo: begin
                    cnt_d[7:0] = bus.rx_data;
                    chk_d      = chk_q ^ bus.rx_data;
                    if ({16'd0, n_words} > (32'd1 << ADDR_W)) state_d = StError;
                    else if (n_words == 16'd0)                 state_d = StCheck;
                    else                                       state_d = StData;
                end
                StData: begin
                    // Shift in from the top so the first byte lands in bits 7:0 after four.
                    word_d = {bus.rx_data, word_q[31:8]};
                    chk_d  = chk_q ^ bus.rx_data;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = widx_q[ADDR_W-1:0];
                        wdata_d = {bus.rx_data, word_q[31:8]};
                        widx_d  = widx_q + 16'd1;
                        if (widx_q == cnt_q - 16'd1) state_d = StCheck;
                    end
                end
                StCheck: begin
                    state_d = (bus.rx_data == chk_q) ? StDone : StError;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            widx_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = active;
    assign load_done      = (state_q == StDone);
    assign load_error     = (state_q == StError);
    assign cpu_reset      = (state_q != StDone);
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued as frames are sent.
module tb_program_loader;
    localparam int unsigned ADDR_W = 13;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_low = 1'b0;
    logic cpu_reset, busy, load_done, load_error;
    logic drv_fourth = 1'b0;
    logic prev_fourth = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic [31:0] words[$];

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(
        .ADDR_W        (ADDR_W),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk       (clk),
        .reset_low (reset_low),
        .bus       (bus.master),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every pulse must match the queue head and follow a 4th data byte.
    always @(negedge clk) begin
        exp_t e;
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("we_addr", 32'(bus.imem_addr), 32'(e.addr));
                check_eq("we_data", bus.imem_wdata, e.data);
                check_eq("we_latency", 32'(prev_fourth), 32'd1);
            end
        end
        if (load_done === 1'b1 && load_error === 1'b1) check_eq("done_err_excl", 32'd1, 32'd0);
        prev_fourth = bus.rx_valid && drv_fourth && reset_low;
    end

    task automatic send_byte(input logic [7:0] b, input logic fourth);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        drv_fourth   = fourth;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
            drv_fourth   = 1'b0;
        end
    endtask

    task automatic check_status(input string tag, input logic rst, input logic bsy,
                                input logic dn, input logic er);
        @(negedge clk);
        check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(rst));
        check_eq({tag, "_busy"}, 32'(busy), 32'(bsy));
        check_eq({tag, "_done"}, 32'(load_done), 32'(dn));
        check_eq({tag, "_error"}, 32'(load_error), 32'(er));
    endtask

    // Sends a whole frame built from `words`; corrupt flips the checksum LSB.
    task automatic send_frame(input int n, input logic corrupt);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [15:0] nn;
        nn  = 16'(n);
        chk = nn[15:8] ^ nn[7:0];
        send_byte(8'hA5, 1'b0);
        send_byte(nn[15:8], 1'b0);
        check_status("in_frame", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(nn[7:0], 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b   = words[i][8*k +: 8];
                chk = chk ^ b;
                if (k == 3) exp_q.push_back('{addr: ADDR_W'(i), data: words[i]});
                send_byte(b, k == 3);
            end
        end
        send_byte(corrupt ? (chk ^ 8'h01) : chk, 1'b0);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_we", 32'(bus.imem_we), 32'd0);
        check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
        check_eq("rst_wdata", bus.imem_wdata, 32'd0);
        check_status("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset_low = 1'b1;

        // Single word 0x13; checksum 0x12.
        words = '{32'h0000_0013};
        send_frame(1, 1'b0);
        check_status("one_word", 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("one_word_q", 32'(exp_q.size()), 32'd0);

        // Two words, checksum 0x0A.
        words = '{32'h0403_0201, 32'h0807_0605};
        send_frame(2, 1'b0);
        check_status("two_word", 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("two_word_q", 32'(exp_q.size()), 32'd0);

        // Same frame with a bad checksum: words land, frame fails.
        send_frame(2, 1'b1);
        check_status("bad_chk", 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("bad_chk_q", 32'(exp_q.size()), 32'd0);

        // Junk then an oversize count 0x2001.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b0);
        idle(2);
        check_status("oversize", 1'b1, 1'b0, 1'b0, 1'b1);

        // Empty frame: N=0, checksum 0.
        send_frame(0, 1'b0);
        check_status("empty", 1'b0, 1'b0, 1'b1, 1'b0);

        // Timeout: stall 100 cycles after the second data byte.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        idle(1);
        repeat (99) @(posedge clk);
        check_status("tmo_99", 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        check_status("tmo_100", 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset asserted mid-DATA, with the would-be 4th byte presented during reset.
        send_frame(0, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        @(posedge clk);
        #1;
        reset_low    = 1'b0;
        bus.rx_data  = 8'h04;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_we", 32'(bus.imem_we), 32'd0);
        check_eq("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
        check_eq("mid_rst_wdata", bus.imem_wdata, 32'd0);
        check_status("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_low    = 1'b1;
        bus.rx_valid = 1'b0;
        // Data containing the sync value must not restart the frame.
        words = '{32'hDEAD_BEEF, 32'hA5A5_A5A5};
        send_frame(2, 1'b0);
        check_status("after_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("after_rst_q", 32'(exp_q.size()), 32'd0);

        idle(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
